// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, enums and helpers for the load/store unit
//   OP_LOAD / OP_STORE : RV32 major opcodes handled by the unit
//   func3_t            : access size / sign encodings
//   lsu_state_t        : sequencing FSM states
//   size_of(func3)     : access size in bytes (1, 2 or 4)
package lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } func3_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ0  = 3'd1,
    S_WAIT0 = 3'd2,
    S_REQ1  = 3'd3,
    S_WAIT1 = 3'd4,
    S_DONE  = 3'd5
  } lsu_state_t;

  // Illegal encodings fall through to a word size; they never reach memory.
  function automatic logic [2:0] size_of(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: size_of = 3'd1;
      F3_H, F3_HU: size_of = 3'd2;
      default:     size_of = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-enable / write-lane generation and load merge / extend
//   off, sz, phase     : in  byte offset in word, size in bytes, 0 = first word, 1 = second
//   store_data         : in  register value to store
//   rdata0, rdata1     : in  captured read words of the first and second access
//   crossing           : in  access spans two words
//   func3              : in  size/sign encoding
//   be, wdata          : out byte enables and lane-aligned data for the current phase
//   load_data          : out merged and extended load result
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NB    = XLEN / 8,
  parameter int OFS_W = $clog2(NB)
) (
  input  logic [OFS_W-1:0] off,
  input  logic [2:0]       sz,
  input  logic             phase,
  input  logic [XLEN-1:0]  store_data,
  input  logic [XLEN-1:0]  rdata0,
  input  logic [XLEN-1:0]  rdata1,
  input  logic             crossing,
  input  logic [2:0]       func3,
  output logic [NB-1:0]    be,
  output logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  load_data
);

  logic [2*NB-1:0] mask;
  logic [OFS_W:0]  nb_m_off;
  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] hi_part;
  logic [XLEN-1:0] w_ext;

  // Mask is twice the word width so the spill into the next word falls out naturally.
  assign mask     = (((2*NB)'(1) << sz) - (2*NB)'(1)) << off;
  assign nb_m_off = (OFS_W+1)'(NB) - {1'b0, off};

  assign be    = phase ? mask[2*NB-1:NB] : mask[NB-1:0];
  assign wdata = phase ? (store_data >> {nb_m_off, 3'b000})
                       : (store_data << {off, 3'b000});

  assign hi_part = crossing ? (rdata1 << {nb_m_off, 3'b000}) : '0;
  assign raw     = (rdata0 >> {off, 3'b000}) | hi_part;

  if (XLEN == 32) begin : g_w32
    assign w_ext = raw;
  end else begin : g_wwide
    assign w_ext = {{(XLEN-32){raw[31]}}, raw[31:0]};
  end

  always_comb begin
    load_data = '0;
    case (func3)
      F3_B:    load_data = {{(XLEN-8){raw[7]}}, raw[7:0]};
      F3_H:    load_data = {{(XLEN-16){raw[15]}}, raw[15:0]};
      F3_W:    load_data = w_ext;
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, raw[7:0]};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, raw[15:0]};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - sequential load/store unit between execute and data memory
//   clk, reset                         : clock, asynchronous active-high reset
//   req_valid/req_ready                : request handshake (ready only in IDLE)
//   opcode, func3, addr, store_data    : request fields, latched on accept
//   resp_valid, resp_data, resp_fault  : one-cycle completion pulse with result
//   mem_req/mem_gnt, mem_we, mem_addr,
//   mem_be, mem_wdata                  : memory request, held until granted
//   mem_rvalid, mem_rdata              : read data / write ack
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter bit ALLOW_MISAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [6:0]           opcode,
  input  logic [2:0]           func3,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [XLEN-1:0]      store_data,
  output logic                 resp_valid,
  output logic [XLEN-1:0]      resp_data,
  output logic                 resp_fault,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [XLEN/8-1:0]    mem_be,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [XLEN-1:0]      mem_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFS_W = $clog2(NB);

  lsu_state_t        state, state_nx;
  logic              we_q, crossing_q, fault_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   sdata_q, rdata0_q, rdata1_q;

  logic              accept, legal, in_crossing, in_fault;
  logic [OFS_W+1:0]  end_ofs;
  logic [ADDR_W-1:0] word0, word1;
  logic [NB-1:0]     be;
  logic [XLEN-1:0]   wdata, load_data;

  // Request decode, evaluated only on accept.
  always_comb begin
    legal = 1'b0;
    if (opcode == OP_LOAD)
      legal = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W) ||
              (func3 == F3_BU) || (func3 == F3_HU);
    else if (opcode == OP_STORE)
      legal = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W);
  end

  assign end_ofs     = {2'b00, addr[OFS_W-1:0]} + (OFS_W+2)'(size_of(func3));
  assign in_crossing = end_ofs > (OFS_W+2)'(NB);
  assign in_fault    = !legal || (in_crossing && !ALLOW_MISAL);
  assign accept      = req_valid && req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      crossing_q <= 1'b0;
      fault_q    <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      sdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q       <= (opcode == OP_STORE);
        crossing_q <= in_crossing;
        fault_q    <= in_fault;
        f3_q       <= func3;
        addr_q     <= addr;
        sdata_q    <= store_data;
      end
      if (state == S_WAIT0 && mem_rvalid) rdata0_q <= mem_rdata;
      if (state == S_WAIT1 && mem_rvalid) rdata1_q <= mem_rdata;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (req_valid) state_nx = in_fault ? S_DONE : S_REQ0;
      S_REQ0:  if (mem_gnt) state_nx = S_WAIT0;
      S_WAIT0: if (mem_rvalid) state_nx = crossing_q ? S_REQ1 : S_DONE;
      S_REQ1:  if (mem_gnt) state_nx = S_WAIT1;
      S_WAIT1: if (mem_rvalid) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign word0 = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
  assign word1 = word0 + ADDR_W'(NB);

  lsu_align #(.XLEN(XLEN), .NB(NB), .OFS_W(OFS_W)) u_align (
    .off        (addr_q[OFS_W-1:0]),
    .sz         (size_of(f3_q)),
    .phase      (state == S_REQ1),
    .store_data (sdata_q),
    .rdata0     (rdata0_q),
    .rdata1     (rdata1_q),
    .crossing   (crossing_q),
    .func3      (f3_q),
    .be         (be),
    .wdata      (wdata),
    .load_data  (load_data)
  );

  // Memory-side outputs are gated so they read zero whenever no request is out.
  assign mem_req   = (state == S_REQ0) || (state == S_REQ1);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = !mem_req ? '0 : (state == S_REQ1) ? word1 : word0;
  assign mem_be    = mem_req ? be : '0;
  assign mem_wdata = mem_req ? wdata : '0;

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_DONE);
  assign resp_fault = resp_valid && fault_q;
  assign resp_data  = (resp_valid && !fault_q && !we_q) ? load_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [31:0] addr, store_data;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_data;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  // Second instance with misaligned accesses disallowed; its memory never answers.
  logic        req_valid_n, req_ready_n;
  logic [6:0]  opcode_n;
  logic [2:0]  func3_n;
  logic [31:0] addr_n, store_data_n;
  logic        resp_valid_n, resp_fault_n;
  logic [31:0] resp_data_n;
  logic        mem_req_n, mem_we_n, mem_gnt_n, mem_rvalid_n;
  logic [31:0] mem_addr_n, mem_wdata_n, mem_rdata_n;
  logic [3:0]  mem_be_n;

  int passed = 0;
  int total  = 0;

  // Results of the most recent run_access.
  int          n_acc, lat, req_cycles, unstable;
  logic        got_valid, got_fault, ready_in_resp;
  logic [31:0] got_data;
  logic [31:0] acc_addr [4];
  logic [31:0] acc_wdata[4];
  logic [3:0]  acc_be   [4];
  logic        acc_we   [4];

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISAL(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .func3(func3), .addr(addr), .store_data(store_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  load_store_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISAL(1'b0)) dut_n (
    .clk(clk), .reset(reset), .req_valid(req_valid_n), .req_ready(req_ready_n),
    .opcode(opcode_n), .func3(func3_n), .addr(addr_n), .store_data(store_data_n),
    .resp_valid(resp_valid_n), .resp_data(resp_data_n), .resp_fault(resp_fault_n),
    .mem_req(mem_req_n), .mem_we(mem_we_n), .mem_addr(mem_addr_n), .mem_be(mem_be_n),
    .mem_wdata(mem_wdata_n), .mem_gnt(mem_gnt_n), .mem_rvalid(mem_rvalid_n),
    .mem_rdata(mem_rdata_n)
  );

  // Issues one request and plays the memory: gnt after gnt_delay waiting cycles,
  // rvalid the cycle after gnt with rd0 / rd1 for the first / second access.
  task automatic run_access(input logic [6:0] op, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rd0, input logic [31:0] rd1,
                            input int gnt_delay);
    int   cyc, wait_gnt;
    logic pending;
    logic [31:0] rd_next;
    n_acc = 0; lat = 0; req_cycles = 0; unstable = 0;
    got_valid = 1'b0; got_fault = 1'b0; got_data = '0; ready_in_resp = 1'b0;
    cyc = 0; wait_gnt = 0; pending = 1'b0; rd_next = '0;
    @(negedge clk);
    opcode = op; func3 = f3; addr = a; store_data = sd; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; opcode = 7'h7f; func3 = 3'b111; addr = 32'hFFFF_FFFF; store_data = '0;
    while (!got_valid && cyc < 60) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h5A5A_5A5A;
      if (pending) begin
        mem_rvalid = 1'b1; mem_rdata = rd_next; pending = 1'b0;
      end
      if (resp_valid) begin
        got_valid = 1'b1; got_data = resp_data; got_fault = resp_fault;
        ready_in_resp = req_ready; lat = cyc + 1;
      end else if (mem_req) begin
        req_cycles++;
        if (n_acc < 4) begin
          if (wait_gnt == 0) begin
            acc_addr[n_acc] = mem_addr; acc_be[n_acc] = mem_be;
            acc_wdata[n_acc] = mem_wdata; acc_we[n_acc] = mem_we;
          end else if (mem_addr !== acc_addr[n_acc] || mem_be !== acc_be[n_acc] ||
                       mem_wdata !== acc_wdata[n_acc] || mem_we !== acc_we[n_acc]) begin
            unstable++;
          end
        end
        if (wait_gnt >= gnt_delay) begin
          mem_gnt = 1'b1; pending = 1'b1;
          rd_next = (n_acc == 0) ? rd0 : rd1;
          n_acc++; wait_gnt = 0;
        end else begin
          wait_gnt++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #3;
    total++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else passed++;
    total++; if ({resp_valid, resp_fault, mem_req, mem_we} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {resp_valid, resp_fault, mem_req, mem_we}); else passed++;
    total++; if ({resp_data, mem_addr, mem_wdata, mem_be} !== 100'd0)
      $display("FAIL reset_data: got %h want 0", {resp_data, mem_addr, mem_wdata, mem_be}); else passed++;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lw_aligned;
    run_access(7'b0000011, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 32'h0, 0);
    total++; if (got_valid !== 1'b1) $display("FAIL lw_resp: got %b want 1", got_valid); else passed++;
    total++; if (n_acc !== 1) $display("FAIL lw_nacc: got %0d want 1", n_acc); else passed++;
    total++; if ({acc_addr[0], acc_be[0], acc_we[0]} !== {32'h100, 4'b1111, 1'b0})
      $display("FAIL lw_req: got %h/%b/%b want 00000100/1111/0", acc_addr[0], acc_be[0], acc_we[0]); else passed++;
    total++; if (got_data !== 32'hDEAD_BEEF) $display("FAIL lw_data: got %h want deadbeef", got_data); else passed++;
    total++; if (got_fault !== 1'b0) $display("FAIL lw_fault: got %b want 0", got_fault); else passed++;
    total++; if (lat !== 3) $display("FAIL lw_latency: got %0d want 3", lat); else passed++;
    total++; if (ready_in_resp !== 1'b0) $display("FAIL lw_ready_in_resp: got %b want 0", ready_in_resp); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL lw_ready_after: got %b want 1", req_ready); else passed++;
  endtask

  task automatic test_lb_lbu;
    run_access(7'b0000011, 3'b000, 32'h103, 32'h0, 32'h8012_3456, 32'h0, 0);
    total++; if ({acc_addr[0], acc_be[0]} !== {32'h100, 4'b1000})
      $display("FAIL lb_req: got %h/%b want 00000100/1000", acc_addr[0], acc_be[0]); else passed++;
    total++; if (got_data !== 32'hFFFF_FF80) $display("FAIL lb_data: got %h want ffffff80", got_data); else passed++;
    run_access(7'b0000011, 3'b100, 32'h103, 32'h0, 32'h8012_3456, 32'h0, 0);
    total++; if (got_data !== 32'h0000_0080) $display("FAIL lbu_data: got %h want 00000080", got_data); else passed++;
    run_access(7'b0000011, 3'b101, 32'h102, 32'h0, 32'h8001_5555, 32'h0, 0);
    total++; if (got_data !== 32'h0000_8001) $display("FAIL lhu_data: got %h want 00008001", got_data); else passed++;
  endtask

  task automatic test_sh;
    run_access(7'b0100011, 3'b001, 32'h102, 32'h1234_ABCD, 32'hFFFF_FFFF, 32'h0, 0);
    total++; if ({acc_addr[0], acc_be[0], acc_we[0]} !== {32'h100, 4'b1100, 1'b1})
      $display("FAIL sh_req: got %h/%b/%b want 00000100/1100/1", acc_addr[0], acc_be[0], acc_we[0]); else passed++;
    total++; if (acc_wdata[0] !== 32'hABCD_0000) $display("FAIL sh_wdata: got %h want abcd0000", acc_wdata[0]); else passed++;
    total++; if (got_data !== 32'h0) $display("FAIL sh_data: got %h want 00000000", got_data); else passed++;
  endtask

  task automatic test_misaligned;
    run_access(7'b0000011, 3'b010, 32'h103, 32'h0, 32'h44AA_BBCC, 32'h9933_2211, 0);
    total++; if (n_acc !== 2) $display("FAIL lwx_nacc: got %0d want 2", n_acc); else passed++;
    total++; if ({acc_addr[0], acc_be[0], acc_addr[1], acc_be[1]} !== {32'h100, 4'b1000, 32'h104, 4'b0111})
      $display("FAIL lwx_req: got %h/%b %h/%b want 00000100/1000 00000104/0111",
               acc_addr[0], acc_be[0], acc_addr[1], acc_be[1]); else passed++;
    total++; if (got_data !== 32'h3322_1144) $display("FAIL lwx_data: got %h want 33221144", got_data); else passed++;
    run_access(7'b0100011, 3'b010, 32'h102, 32'h1122_3344, 32'h0, 32'h0, 0);
    total++; if ({acc_be[0], acc_wdata[0], acc_be[1], acc_wdata[1]} !== {4'b1100, 32'h3344_0000, 4'b0011, 32'h0000_1122})
      $display("FAIL swx_lanes: got %b/%h %b/%h want 1100/33440000 0011/00001122",
               acc_be[0], acc_wdata[0], acc_be[1], acc_wdata[1]); else passed++;
    run_access(7'b0000011, 3'b001, 32'hFFFF_FFFF, 32'h0, 32'hAB00_0000, 32'h0000_00CD, 0);
    total++; if ({acc_addr[0], acc_be[0], acc_addr[1], acc_be[1]} !== {32'hFFFF_FFFC, 4'b1000, 32'h0, 4'b0001})
      $display("FAIL lhwrap_req: got %h/%b %h/%b want fffffffc/1000 00000000/0001",
               acc_addr[0], acc_be[0], acc_addr[1], acc_be[1]); else passed++;
    total++; if (got_data !== 32'hFFFF_CDAB) $display("FAIL lhwrap_data: got %h want ffffcdab", got_data); else passed++;
  endtask

  task automatic test_faults;
    int   cyc;
    logic saw_req, saw_resp, f_fault;
    logic [31:0] f_data;
    run_access(7'b0000011, 3'b011, 32'h100, 32'h0, 32'h1234_5678, 32'h0, 0);
    total++; if ({got_valid, got_fault, n_acc == 0} !== 3'b111)
      $display("FAIL f3_011: got valid=%b fault=%b acc=%0d want 1 1 0", got_valid, got_fault, n_acc); else passed++;
    total++; if (got_data !== 32'h0) $display("FAIL f3_011_data: got %h want 00000000", got_data); else passed++;
    run_access(7'b0100011, 3'b100, 32'h100, 32'h0, 32'h0, 32'h0, 0);
    total++; if ({got_fault, n_acc == 0} !== 2'b11)
      $display("FAIL sbu_fault: got fault=%b acc=%0d want 1 0", got_fault, n_acc); else passed++;
    run_access(7'b0110011, 3'b010, 32'h100, 32'h0, 32'h0, 32'h0, 0);
    total++; if ({got_fault, n_acc == 0} !== 2'b11)
      $display("FAIL badop_fault: got fault=%b acc=%0d want 1 0", got_fault, n_acc); else passed++;
    // Word-crossing LW on the instance that disallows it.
    saw_req = 1'b0; saw_resp = 1'b0; f_fault = 1'b0; f_data = 32'hFFFF_FFFF;
    @(negedge clk);
    opcode_n = 7'b0000011; func3_n = 3'b010; addr_n = 32'h103; req_valid_n = 1'b1;
    @(negedge clk);
    req_valid_n = 1'b0;
    for (cyc = 0; cyc < 6; cyc++) begin
      if (mem_req_n) saw_req = 1'b1;
      if (resp_valid_n && !saw_resp) begin
        saw_resp = 1'b1; f_fault = resp_fault_n; f_data = resp_data_n;
      end
      @(negedge clk);
    end
    total++; if (saw_req !== 1'b0) $display("FAIL nomisal_req: got %b want 0", saw_req); else passed++;
    total++; if ({saw_resp, f_fault} !== 2'b11)
      $display("FAIL nomisal_fault: got valid=%b fault=%b want 1 1", saw_resp, f_fault); else passed++;
    total++; if (f_data !== 32'h0) $display("FAIL nomisal_data: got %h want 00000000", f_data); else passed++;
  endtask

  task automatic test_gnt_stall;
    run_access(7'b0000011, 3'b010, 32'h200, 32'h0, 32'hCAFE_F00D, 32'h0, 5);
    total++; if (req_cycles !== 6) $display("FAIL stall_req_cycles: got %0d want 6", req_cycles); else passed++;
    total++; if (unstable !== 0) $display("FAIL stall_stable: got %0d changes want 0", unstable); else passed++;
    total++; if (acc_addr[0] !== 32'h200) $display("FAIL stall_addr: got %h want 00000200", acc_addr[0]); else passed++;
    total++; if (got_data !== 32'hCAFE_F00D) $display("FAIL stall_data: got %h want cafef00d", got_data); else passed++;
    total++; if (lat !== 8) $display("FAIL stall_latency: got %0d want 8", lat); else passed++;
  endtask

  task automatic test_reset_mid_access;
    logic was_wait;
    @(negedge clk);
    opcode = 7'b0000011; func3 = 3'b010; addr = 32'h300; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    was_wait = !mem_req && !resp_valid && !req_ready;
    #2 reset = 1'b1;
    #1;
    total++; if (was_wait !== 1'b1) $display("FAIL midrst_in_wait: got %b want 1", was_wait); else passed++;
    total++; if ({req_ready, resp_valid, mem_req, mem_be} !== 7'b1000000)
      $display("FAIL midrst_outputs: got ready=%b valid=%b req=%b be=%b want 1 0 0 0000",
               req_ready, resp_valid, mem_req, mem_be); else passed++;
    @(negedge clk);
    reset = 1'b0;
    run_access(7'b0000011, 3'b010, 32'h300, 32'h0, 32'h0BAD_F00D, 32'h0, 0);
    total++; if ({n_acc == 1, acc_addr[0]} !== {1'b1, 32'h300})
      $display("FAIL midrst_next_req: got acc=%0d addr=%h want 1 00000300", n_acc, acc_addr[0]); else passed++;
    total++; if (got_data !== 32'h0BAD_F00D) $display("FAIL midrst_next_data: got %h want 0badf00d", got_data); else passed++;
  endtask

  initial begin
    req_valid = 1'b0; opcode = '0; func3 = '0; addr = '0; store_data = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    req_valid_n = 1'b0; opcode_n = '0; func3_n = '0; addr_n = '0; store_data_n = '0;
    mem_gnt_n = 1'b0; mem_rvalid_n = 1'b0; mem_rdata_n = '0;
    test_reset;
    test_lw_aligned;
    test_lb_lbu;
    test_sh;
    test_misaligned;
    test_faults;
    test_gnt_stall;
    test_reset_mid_access;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
